// File: rtl/monitor_temperatura_reator.sv
// Reactor temperature monitor: confirms HIGH/LOW excursions over N_CONFIRMA
// consecutive samples with hysteresis, and detects sensor faults and sample starvation.
module monitor_temperatura_reator #(
    parameter int LIMIAR_ALTO  = 200,
    parameter int LIMIAR_BAIXO = 180,
    parameter int N_CONFIRMA   = 3,
    parameter int TIMEOUT      = 1000
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic [7:0] temperatura,
    input  logic       amostra_valida,
    output logic       S,
    output logic       falha_sensor,
    output logic       amostra_aceita
);

    typedef enum logic [2:0] {
        NORMAL,
        SUSPEITA_ALTA,
        ALERTA,
        SUSPEITA_BAIXA,
        FALHA
    } t_estado;

    typedef enum logic [1:0] {
        C_MID,
        C_BAIXO,
        C_ALTO,
        C_FALHA
    } t_classe;

    // Thresholds held at 9 bits so LIMIAR_ALTO = 256 (never HIGH) stays representable.
    localparam logic [8:0]  ALTO   = 9'(LIMIAR_ALTO);
    localparam logic [8:0]  BAIXO  = 9'(LIMIAR_BAIXO);
    localparam logic [3:0]  N_C    = 4'(N_CONFIRMA);
    localparam logic [15:0] WD_MAX = 16'(TIMEOUT);
    localparam logic [15:0] WD_EXP = 16'(TIMEOUT - 1);

    function automatic t_classe f_classifica(input logic [7:0] t);
        t_classe c;
        if (t == 8'hFF)
            c = C_FALHA;
        else if ({1'b0, t} >= ALTO)
            c = C_ALTO;
        else if ({1'b0, t} < BAIXO)
            c = C_BAIXO;
        else
            c = C_MID;
        return c;
    endfunction

    t_estado     r_estado;
    logic [3:0]  r_conf;
    logic [15:0] r_wd;
    logic        r_aceita;

    t_estado     w_estado_prox;
    logic [3:0]  w_conf_prox;
    logic [3:0]  w_conf_inc;
    logic [15:0] w_wd_prox;
    logic        w_expira;
    t_classe     w_classe;

    assign w_classe   = f_classifica(temperatura);
    assign w_conf_inc = r_conf + 4'd1;
    assign w_expira   = !amostra_valida && (r_wd == WD_EXP);
    // Watchdog parks at TIMEOUT so it fires once per starvation period.
    assign w_wd_prox  = amostra_valida     ? 16'd0 :
                        (r_wd == WD_MAX)   ? r_wd  : r_wd + 16'd1;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_estado <= NORMAL;
            r_conf   <= 4'd0;
            r_wd     <= 16'd0;
            r_aceita <= 1'b0;
        end else begin
            r_estado <= w_estado_prox;
            r_conf   <= w_conf_prox;
            r_wd     <= w_wd_prox;
            r_aceita <= amostra_valida;
        end
    end

    always_comb begin
        w_estado_prox = r_estado;
        w_conf_prox   = r_conf;
        if (amostra_valida) begin
            if (w_classe == C_FALHA) begin
                w_estado_prox = FALHA;
                w_conf_prox   = 4'd0;
            end else begin
                case (r_estado)
                    NORMAL: begin
                        if (w_classe == C_ALTO) begin
                            if (N_C == 4'd1) begin
                                w_estado_prox = ALERTA;
                                w_conf_prox   = 4'd0;
                            end else begin
                                w_estado_prox = SUSPEITA_ALTA;
                                w_conf_prox   = 4'd1;
                            end
                        end
                    end
                    SUSPEITA_ALTA: begin
                        if (w_classe == C_ALTO) begin
                            if (w_conf_inc == N_C) begin
                                w_estado_prox = ALERTA;
                                w_conf_prox   = 4'd0;
                            end else begin
                                w_conf_prox   = w_conf_inc;
                            end
                        end else begin
                            w_estado_prox = NORMAL;
                            w_conf_prox   = 4'd0;
                        end
                    end
                    ALERTA: begin
                        if (w_classe == C_BAIXO) begin
                            if (N_C == 4'd1) begin
                                w_estado_prox = NORMAL;
                                w_conf_prox   = 4'd0;
                            end else begin
                                w_estado_prox = SUSPEITA_BAIXA;
                                w_conf_prox   = 4'd1;
                            end
                        end
                    end
                    SUSPEITA_BAIXA: begin
                        if (w_classe == C_BAIXO) begin
                            if (w_conf_inc == N_C) begin
                                w_estado_prox = NORMAL;
                                w_conf_prox   = 4'd0;
                            end else begin
                                w_conf_prox   = w_conf_inc;
                            end
                        end else begin
                            w_estado_prox = ALERTA;
                            w_conf_prox   = 4'd0;
                        end
                    end
                    FALHA: begin
                        // Recovery from a fault always lands in ALERTA, never NORMAL.
                        if (w_conf_inc == N_C) begin
                            w_estado_prox = ALERTA;
                            w_conf_prox   = 4'd0;
                        end else begin
                            w_conf_prox   = w_conf_inc;
                        end
                    end
                    default: begin
                        w_estado_prox = NORMAL;
                        w_conf_prox   = 4'd0;
                    end
                endcase
            end
        end else if (w_expira) begin
            w_estado_prox = FALHA;
            w_conf_prox   = 4'd0;
        end
    end

    always_comb begin
        S              = (r_estado == ALERTA) || (r_estado == SUSPEITA_BAIXA) ||
                         (r_estado == FALHA);
        falha_sensor   = (r_estado == FALHA);
        amostra_aceita = r_aceita;
    end

endmodule

// File: tb/tb_monitor_temperatura_reator.sv
// Randomised and directed bench for monitor_temperatura_reator, checked against
// a flag-and-counter behavioural model of the alarm hysteresis and watchdog.
module tb_monitor_temperatura_reator;

    localparam int ALTO    = 200;
    localparam int BAIXO   = 180;
    localparam int N       = 3;
    localparam int TIMEOUT = 1000;

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b1;
    logic [7:0] temperatura = 8'd0;
    logic       amostra_valida = 1'b0;
    logic       S;
    logic       falha_sensor;
    logic       amostra_aceita;

    int n_checks = 0;
    int n_erros  = 0;

    // Model: m_alarme is the overheat level, m_falha the fault flag,
    // m_seq the length of the current confirming run, m_ocioso idle cycles.
    bit m_alarme, m_falha, m_aceita;
    int m_seq, m_ocioso;

    monitor_temperatura_reator #(
        .LIMIAR_ALTO (ALTO),
        .LIMIAR_BAIXO(BAIXO),
        .N_CONFIRMA  (N),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET_N       (RESET_N),
        .temperatura   (temperatura),
        .amostra_valida(amostra_valida),
        .S             (S),
        .falha_sensor  (falha_sensor),
        .amostra_aceita(amostra_aceita)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic modelo_reset();
        m_alarme = 0; m_falha = 0; m_aceita = 0; m_seq = 0; m_ocioso = 0;
    endtask

    task automatic modelo_passo(input logic v, input logic [7:0] t);
        int ti;
        ti = int'(t);
        if (v) begin
            m_ocioso = 0;
            if (t == 8'hFF) begin
                m_falha = 1; m_alarme = 1; m_seq = 0;
            end else if (m_falha) begin
                m_seq++;
                if (m_seq >= N) begin m_falha = 0; m_seq = 0; end
            end else if (!m_alarme) begin
                if (ti >= ALTO) m_seq++; else m_seq = 0;
                if (m_seq >= N) begin m_alarme = 1; m_seq = 0; end
            end else begin
                if (ti < BAIXO) m_seq++; else m_seq = 0;
                if (m_seq >= N) begin m_alarme = 0; m_seq = 0; end
            end
        end else begin
            if (m_ocioso == TIMEOUT - 1) begin
                m_falha = 1; m_alarme = 1; m_seq = 0;
            end
            if (m_ocioso < TIMEOUT) m_ocioso++;
        end
        m_aceita = v;
    endtask

    // Drives one cycle; returns 1 ns after the rising edge with the model updated.
    task automatic ciclo(input logic v, input logic [7:0] t);
        amostra_valida = v;
        temperatura    = t;
        @(posedge CLOCK);
        modelo_passo(v, t);
        #1;
        amostra_valida = 1'b0;
    endtask

    task automatic aplicar_reset(input string nome);
        RESET_N = 1'b0;
        #2;
        n_checks++;
        if ({S, falha_sensor, amostra_aceita} !== 3'b000) begin
            n_erros++;
            $display("FAIL %s: S/falha/aceita=%b%b%b required 000 while reset low",
                     nome, S, falha_sensor, amostra_aceita);
        end
        RESET_N = 1'b1;
        #1;
        modelo_reset();
    endtask

    task automatic test_reset();
        #1 RESET_N = 1'b0;
        #2;
        n_checks++;
        if ({S, falha_sensor, amostra_aceita} !== 3'b000) begin
            n_erros++;
            $display("FAIL reset_inicial: S/falha/aceita=%b%b%b required 000",
                     S, falha_sensor, amostra_aceita);
        end
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        modelo_reset();
    endtask

    task automatic test_confirmacao_alta();
        logic [7:0] seq_b [4] = '{8'd210, 8'd210, 8'd190, 8'd210};
        for (int i = 0; i < 3; i++) begin
            ciclo(1'b1, 8'd210);
            n_checks++;
            if (S !== (i == 2) || S !== (m_alarme | m_falha)) begin
                n_erros++;
                $display("FAIL alta_confirma[%0d]: S=%b required %b", i, S, (i == 2));
            end
        end
        aplicar_reset("reset_alta");
        for (int i = 0; i < 4; i++) begin
            ciclo(1'b1, seq_b[i]);
            n_checks++;
            if (S !== 1'b0 || amostra_aceita !== 1'b1) begin
                n_erros++;
                $display("FAIL alta_interrompida[%0d]: S=%b aceita=%b required 0 1",
                         i, S, amostra_aceita);
            end
        end
    endtask

    task automatic test_histerese_baixa();
        logic [7:0] seq_t [5] = '{8'd170, 8'd185, 8'd170, 8'd170, 8'd170};
        logic       esp   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        aplicar_reset("reset_histerese");
        repeat (3) ciclo(1'b1, 8'd210);
        for (int i = 0; i < 5; i++) begin
            ciclo(1'b1, seq_t[i]);
            n_checks++;
            if (S !== esp[i] || falha_sensor !== 1'b0) begin
                n_erros++;
                $display("FAIL histerese[%0d]: S=%b falha=%b required %b 0",
                         i, S, falha_sensor, esp[i]);
            end
        end
    endtask

    task automatic test_falha_sensor();
        logic [1:0] esp [7] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
        aplicar_reset("reset_falha");
        for (int i = 0; i < 7; i++) begin
            ciclo(1'b1, (i == 0) ? 8'hFF : 8'd100);
            n_checks++;
            if ({S, falha_sensor} !== esp[i] ||
                {S, falha_sensor} !== {m_alarme | m_falha, m_falha}) begin
                n_erros++;
                $display("FAIL falha_sensor[%0d]: S/falha=%b%b required %b",
                         i, S, falha_sensor, esp[i]);
            end
        end
    endtask

    task automatic test_watchdog();
        aplicar_reset("reset_wd");
        for (int i = 1; i <= TIMEOUT; i++) begin
            ciclo(1'b0, 8'd0);
            n_checks++;
            if (falha_sensor !== (i == TIMEOUT) || S !== (i == TIMEOUT)) begin
                n_erros++;
                $display("FAIL wd_expira ciclo %0d: falha=%b S=%b required %b",
                         i, falha_sensor, S, (i == TIMEOUT));
            end
        end
        aplicar_reset("reset_wd2");
        repeat (TIMEOUT - 1) ciclo(1'b0, 8'd0);
        ciclo(1'b1, 8'd100);
        repeat (5) ciclo(1'b0, 8'd0);
        n_checks++;
        if (falha_sensor !== 1'b0 || S !== 1'b0) begin
            n_erros++;
            $display("FAIL wd_precedencia: falha=%b S=%b required 0 0", falha_sensor, S);
        end
        // One sample into recovery, then starve again: the run must restart.
        aplicar_reset("reset_wd3");
        ciclo(1'b1, 8'hFF);
        ciclo(1'b1, 8'd100);
        repeat (TIMEOUT) ciclo(1'b0, 8'd0);
        for (int i = 0; i < N; i++) begin
            ciclo(1'b1, 8'd100);
            n_checks++;
            if (falha_sensor !== (i < N - 1) || falha_sensor !== m_falha || S !== 1'b1) begin
                n_erros++;
                $display("FAIL wd_reexpira[%0d]: falha=%b S=%b required %b 1",
                         i, falha_sensor, S, (i < N - 1));
            end
        end
    endtask

    task automatic test_reset_meio();
        aplicar_reset("reset_meio_a");
        ciclo(1'b1, 8'd210);
        ciclo(1'b1, 8'd210);
        aplicar_reset("reset_meio_b");
        for (int i = 0; i < N; i++) begin
            ciclo(1'b1, 8'd210);
            n_checks++;
            if (S !== (i == N - 1)) begin
                n_erros++;
                $display("FAIL reset_meio[%0d]: S=%b required %b", i, S, (i == N - 1));
            end
        end
    endtask

    function automatic logic [7:0] gera_temp(input bit com_falha);
        int c;
        c = int'($urandom_range(com_falha ? 0 : 1, 9));
        if (c == 0)      return 8'hFF;
        else if (c <= 3) return 8'($urandom_range(ALTO, 254));
        else if (c <= 6) return 8'($urandom_range(0, BAIXO - 1));
        else             return 8'($urandom_range(BAIXO, ALTO - 1));
    endfunction

    task automatic test_back_to_back();
        aplicar_reset("reset_b2b");
        for (int i = 0; i < TIMEOUT + 100; i++) begin
            ciclo(1'b1, gera_temp(1'b0));
            n_checks++;
            if (amostra_aceita !== 1'b1 || falha_sensor !== 1'b0 ||
                S !== (m_alarme | m_falha)) begin
                n_erros++;
                $display("FAIL back_to_back[%0d]: aceita=%b falha=%b S=%b required 1 0 %b",
                         i, amostra_aceita, falha_sensor, S, m_alarme | m_falha);
            end
        end
    endtask

    task automatic test_aleatorio();
        aplicar_reset("reset_aleatorio");
        for (int i = 0; i < 3000; i++) begin
            ciclo(($urandom_range(0, 9) < 7), gera_temp(1'b1));
            n_checks++;
            if ({S, falha_sensor, amostra_aceita} !==
                {m_alarme | m_falha, m_falha, m_aceita}) begin
                n_erros++;
                $display("FAIL aleatorio[%0d]: S/falha/aceita=%b%b%b required %b%b%b",
                         i, S, falha_sensor, amostra_aceita,
                         m_alarme | m_falha, m_falha, m_aceita);
            end
        end
    endtask

    initial begin
        modelo_reset();
        test_reset();
        test_confirmacao_alta();
        test_histerese_baixa();
        test_falha_sensor();
        test_watchdog();
        test_reset_meio();
        test_back_to_back();
        test_aleatorio();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_erros);
        $finish;
    end

endmodule
